// File: rtl/fpflt_arb_pkg.sv
// Shared types and widths for the fpflt request arbiter.
// The FSM encoding, flag width and operand width live here so the arbiter and bench agree.
package fpflt_arb_pkg;
    localparam int OP_W   = 32;
    localparam int FLAG_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/fpflt_arb_rr_pick.sv
// Combinational round-robin search: first set valid bit at or above ptr, wrapping to 0.
// ptr is assumed to be below NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);
    localparam logic [IDW:0] N = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] rot;
    logic [IDW:0]      sum;
    logic              found;

    assign dbl = {valid, valid};

    // Rotating the doubled vector puts ptr at bit 0, so the search is a fixed priority scan.
    always_comb begin
        rot   = dbl >> ptr;
        sum   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IDW+1)'(k);
                if (sum >= N) sum = sum - N;
                idx   = sum[IDW-1:0];
            end
        end
        grant = found ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/fpflt_arb.sv
// Round-robin arbiter sharing one external int-to-float (fpflt) unit among NREQ requesters.
// One operation in flight at a time: IDLE grants, ISSUE/WAIT run the unit, RESP strobes the owner.
module fpflt_arb
    import fpflt_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*OP_W-1:0]   req_x,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [OP_W-1:0]        rsp_z,
    output logic [FLAG_W-1:0]      rsp_flags,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy,
    output logic                   fp_run,
    output logic [OP_W-1:0]        fp_x,
    input  logic                   fp_stall,
    input  logic [OP_W-1:0]        fp_z,
    input  logic [FLAG_W-1:0]      fp_flags,
    output logic [15:0]            ops_done
);
    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_idx;
    logic [OP_W-1:0] win_x;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        win_x = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) win_x = req_x[i*OP_W +: OP_W];
        end
    end

    // fp_x and rsp_id are only written at the grant, so later req_x changes cannot reach the unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            fp_run    <= 1'b0;
            fp_x      <= '0;
            rsp_z     <= '0;
            rsp_flags <= '0;
            rsp_id    <= '0;
            rsp_valid <= '0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        fp_x   <= win_x;
                        rsp_id <= win_idx;
                        fp_run <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!fp_stall) begin
                        rsp_z     <= fp_z;
                        rsp_flags <= fp_flags;
                        fp_run    <= 1'b0;
                        rsp_valid <= NREQ'(1) << rsp_id;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    ops_done  <= ops_done + 16'd1;
                    rr_ptr    <= (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
